acc_rsp_wb_unit: RTL and testbench
==================================

Name: acc_rsp_wb_unit

Overview:
Core-side consumer of the FPU subsystem's C-response channel. Tracks outstanding offloaded instructions with integer destinations in a per-register scoreboard and gives the core a hazard signal. Buffers each response in a one-entry register and writes it back through the core's shared integer register-file write port when that port is free. Converts error or unsupported responses into a one-cycle exception pulse.

Parameters:
MAX_OUTSTANDING, 4, maximum in-flight integer-destination offloads. Must equal the FPU subsystem BUFFER_DEPTH.
CNT_W, $clog2(MAX_OUTSTANDING+1), outstanding-counter width. Derived; do not override.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
issue_valid_i  in  1  core drives C-request valid
issue_ready_i  in  1  FPU subsystem C-request ready
issue_rd_i  in  5  rd field of the offloaded instruction
issue_rd_is_int_i  in  1  instruction writes an integer register; a response will follow
issue_stall_o  out  1  core must not offload an int-dest instruction this cycle
hz_valid_i  in  4  valid mask for {rd, rs3, rs2, rs1} of the decoding instruction
hz_addr_i  in  4x5  packed {rd, rs3, rs2, rs1}
hazard_o  out  1  a valid operand hits a pending register
c_p_valid_i  in  1  response valid
c_p_ready_o  out  1  response ready
c_p_data_i  in  32  result data
c_p_error_i  in  1  response error
c_p_dualwb_i  in  1  dual writeback request (unsupported)
c_p_rd_i  in  5  destination register
core_wb_busy_i  in  1  core's own pipeline owns the write port this cycle
wb_valid_o  out  1  write enable to integer register file
wb_addr_o  out  5  write address
wb_data_o  out  32  write data
error_o  out  1  one-cycle exception pulse
outstanding_o  out  CNT_W  current outstanding count

Behaviour:
- Reset (rst_ni low at a clock edge):
  - clears pend[31:0], cnt, the buffer valid bit, wb_addr/data and error_o.
  - c_p_ready_o is forced 0 while rst_ni is low.
  - Reset mid-operation discards the buffered response and all pending bits. The FPU subsystem is reset in the same cycle.
- Issue accept (iss):
  - iss = issue_valid_i & issue_ready_i & issue_rd_is_int_i.
  - On iss: cnt+1. If issue_rd_i != 0, set pend[issue_rd_i].
- issue_stall_o = (cnt == MAX_OUTSTANDING), combinational.
  - An iss while stalled is a protocol violation: cnt saturates and error_o pulses.
- hazard_o (combinational): OR over i of hz_valid_i[i] & (hz_addr_i[i] != 0) & pend[hz_addr_i[i]].
- Response buffer (one entry, bvalid):
  - c_p_ready_o = !bvalid | drain.
  - On c_p handshake: capture {data, rd, err = c_p_error_i | c_p_dualwb_i}; bvalid <= 1.
  - Latency: handshake in cycle N gives wb_valid_o in cycle N+1.
  - Back-to-back responses are sustained at one per cycle while core_wb_busy_i stays low.
- Drain:
  - drain = bvalid & (err | !core_wb_busy_i).
  - wb_valid_o = bvalid & !err & !core_wb_busy_i & (brd != 0).
  - Writes to x0 are suppressed, but the entry still drains.
  - Error entries drain immediately without writeback and pulse error_o in the drain cycle.
- Retire (on drain):
  - clear pend[brd]; cnt-1.
- Simultaneous iss and retire:
  - Same rd: set wins, so the pend bit stays 1.
  - cnt is unchanged.
- Response with cnt == 0: drop it (no buffer load, no decrement, no underflow), accept it (ready high), and pulse error_o.
- wb_addr_o/wb_data_o hold their last value when wb_valid_o is low.
- The scoreboard is one bit per register. Two in-flight offloads to the same rd are legal: the first retire clears the bit early. The core's decoder therefore also stalls on hazard_o before issuing a WAW to a pending rd.

Decomposition:
- acc_pkg gains:
  - typedef acc_rsp_t {data[31:0], rd[4:0], err}.
  - constant HZ_PORTS = 4.
- One natural sub-module: acc_scoreboard. It holds pend[31:0], the counter, and the set/clear priority, and drives hazard_o, issue_stall_o and outstanding_o.
- The buffer and writeback logic stay in acc_rsp_wb_unit.

Test Plan:
- Issue rd=5 int, response data=0x3F800000 rd=5, core_wb_busy_i=0 -> hazard_o=1 for rs1=5 until the drain cycle; wb_valid_o=1, wb_addr_o=5, wb_data_o=0x3F800000 one cycle after the handshake; pend[5]=0 and outstanding_o=0 afterwards.
- Issue 4 int-dest ops (MAX_OUTSTANDING=4) -> issue_stall_o=1 after the 4th; one retire -> issue_stall_o=0 next cycle.
- Buffered response with core_wb_busy_i=1 for 3 cycles -> wb_valid_o=0 and c_p_ready_o=0 for those 3 cycles; a second c_p_valid stalls; writeback happens on the first free cycle, then the second response follows with no bubble.
- Response with c_p_error_i=1 (or c_p_dualwb_i=1), rd=7 -> no wb_valid_o; error_o high for exactly 1 cycle; pend[7] cleared; cnt decremented.
- Issue rd=9 in the same cycle a pending rd=9 retires -> pend[9] stays 1; outstanding_o unchanged; the second response clears it.
- Response with outstanding_o=0 -> accepted, error_o pulses once, outstanding_o stays 0. Then assert rst_ni=0 with one entry buffered and 2 outstanding -> next cycle all pend=0, outstanding_o=0, wb_valid_o=0.

Source files
------------

// File: rtl/acc_rsp_wb_unit_pkg.sv
// Shared types and constants for the accelerator response writeback unit.
package acc_rsp_wb_unit_pkg;

  localparam int HZ_PORTS = 4;
  localparam int REG_AW   = 5;
  localparam int XLEN     = 32;

  typedef struct packed {
    logic [XLEN-1:0]   data;
    logic [REG_AW-1:0] rd;
    logic              err;
  } acc_rsp_t;

endpackage

// File: rtl/acc_rsp_wb_unit_if.sv
// C-response channel from the FPU subsystem to the core-side writeback unit.
interface acc_rsp_wb_unit_if;
  import acc_rsp_wb_unit_pkg::*;

  logic              valid;
  logic              ready;
  logic [XLEN-1:0]   data;
  logic              error;
  logic              dualwb;
  logic [REG_AW-1:0] rd;

  modport master (output valid, data, error, dualwb, rd, input ready);
  modport slave  (input valid, data, error, dualwb, rd, output ready);

endinterface

// File: rtl/acc_rsp_wb_unit_scoreboard.sv
// Per-register pending scoreboard and outstanding counter for int-dest offloads.
module acc_scoreboard
  import acc_rsp_wb_unit_pkg::*;
#(
  parameter  int MAX_OUTSTANDING = 4,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       iss,
  input  logic [REG_AW-1:0]          iss_rd,
  input  logic                       retire,
  input  logic [REG_AW-1:0]          retire_rd,
  input  logic [HZ_PORTS-1:0]        hz_valid,
  input  logic [HZ_PORTS*REG_AW-1:0] hz_addr,
  output logic                       hazard,
  output logic                       issue_stall,
  output logic                       overflow,
  output logic                       empty,
  output logic [CNT_W-1:0]           outstanding
);

  logic [31:0]      pend;
  logic [31:0]      pend_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             full;

  assign full        = (cnt == CNT_W'(MAX_OUTSTANDING));
  assign empty       = (cnt == '0);
  assign issue_stall = full;
  assign overflow    = iss & full;
  assign outstanding = cnt;

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HZ_PORTS; i++) begin
      if (hz_valid[i] && (hz_addr[i*REG_AW +: REG_AW] != '0) &&
          pend[hz_addr[i*REG_AW +: REG_AW]])
        hazard = 1'b1;
    end
  end

  // Clear first, then set, so a same-rd issue overrides a retire.
  always_comb begin
    pend_nxt = pend;
    if (retire)
      pend_nxt[retire_rd] = 1'b0;
    if (iss && (iss_rd != '0))
      pend_nxt[iss_rd] = 1'b1;
  end

  always_comb begin
    cnt_nxt = cnt;
    unique case ({iss, retire})
      2'b10:   if (!full)  cnt_nxt = cnt + CNT_W'(1);
      2'b01:   if (!empty) cnt_nxt = cnt - CNT_W'(1);
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend <= '0;
      cnt  <= '0;
    end else begin
      pend <= pend_nxt;
      cnt  <= cnt_nxt;
    end
  end

endmodule

// File: rtl/acc_rsp_wb_unit.sv
// Core-side consumer of FPU C-responses: scoreboard, one-entry buffer, shared-port writeback.
module acc_rsp_wb_unit
  import acc_rsp_wb_unit_pkg::*;
#(
  parameter  int MAX_OUTSTANDING = 4,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       issue_valid_i,
  input  logic                       issue_ready_i,
  input  logic [REG_AW-1:0]          issue_rd_i,
  input  logic                       issue_rd_is_int_i,
  output logic                       issue_stall_o,
  input  logic [HZ_PORTS-1:0]        hz_valid_i,
  input  logic [HZ_PORTS*REG_AW-1:0] hz_addr_i,
  output logic                       hazard_o,
  acc_rsp_wb_unit_if.slave           c_p,
  input  logic                       core_wb_busy_i,
  output logic                       wb_valid_o,
  output logic [REG_AW-1:0]          wb_addr_o,
  output logic [XLEN-1:0]            wb_data_o,
  output logic                       error_o,
  output logic [CNT_W-1:0]           outstanding_o
);

  acc_rsp_t          rsp_p1;
  logic              vld_p1;
  logic [REG_AW-1:0] last_addr;
  logic [XLEN-1:0]   last_data;
  logic              err_q;

  logic iss;
  logic drain;
  logic hs;
  logic drop;
  logic load;
  logic sb_empty;
  logic sb_overflow;

  assign iss   = issue_valid_i & issue_ready_i & issue_rd_is_int_i;
  assign drain = vld_p1 & (rsp_p1.err | ~core_wb_busy_i);

  assign c_p.ready = rst_ni & (~vld_p1 | drain);
  assign hs        = c_p.valid & c_p.ready;
  // A response with nothing outstanding is accepted but never buffered.
  assign drop      = hs & sb_empty;
  assign load      = hs & ~sb_empty;

  acc_scoreboard #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_scoreboard (
    .clk         (clk_i),
    .rst_n       (rst_ni),
    .iss         (iss),
    .iss_rd      (issue_rd_i),
    .retire      (drain),
    .retire_rd   (rsp_p1.rd),
    .hz_valid    (hz_valid_i),
    .hz_addr     (hz_addr_i),
    .hazard      (hazard_o),
    .issue_stall (issue_stall_o),
    .overflow    (sb_overflow),
    .empty       (sb_empty),
    .outstanding (outstanding_o)
  );

  // Stage p1: one-entry response buffer
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_p1 <= 1'b0;
      rsp_p1 <= '0;
    end else if (load) begin
      vld_p1 <= 1'b1;
      rsp_p1 <= '{data: c_p.data, rd: c_p.rd, err: c_p.error | c_p.dualwb};
    end else if (drain) begin
      vld_p1 <= 1'b0;
    end
  end

  assign wb_valid_o = vld_p1 & ~rsp_p1.err & ~core_wb_busy_i & (rsp_p1.rd != '0);
  assign wb_addr_o  = wb_valid_o ? rsp_p1.rd   : last_addr;
  assign wb_data_o  = wb_valid_o ? rsp_p1.data : last_data;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_addr <= '0;
      last_data <= '0;
      err_q     <= 1'b0;
    end else begin
      if (wb_valid_o) begin
        last_addr <= rsp_p1.rd;
        last_data <= rsp_p1.data;
      end
      err_q <= drop | sb_overflow;
    end
  end

  // Error entries report in their drain cycle; protocol violations one cycle later.
  assign error_o = err_q | (vld_p1 & rsp_p1.err);

endmodule

// File: tb/tb_acc_rsp_wb_unit.sv
// Directed bench for acc_rsp_wb_unit with hand-computed expectations.
module tb_acc_rsp_wb_unit;
  import acc_rsp_wb_unit_pkg::*;

  localparam int CNT_W = $clog2(4 + 1);

  logic             clk = 1'b0;
  logic             rst_ni;
  logic             issue_valid, issue_ready, issue_rd_is_int;
  logic [4:0]       issue_rd;
  logic             issue_stall;
  logic [3:0]       hz_valid;
  logic [19:0]      hz_addr;
  logic             hazard;
  logic             core_wb_busy;
  logic             wb_valid;
  logic [4:0]       wb_addr;
  logic [31:0]      wb_data;
  logic             error;
  logic [CNT_W-1:0] outstanding;

  int n_cmp = 0;
  int n_mis = 0;

  acc_rsp_wb_unit_if cp();

  acc_rsp_wb_unit #(.MAX_OUTSTANDING(4)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_ni),
    .issue_valid_i     (issue_valid),
    .issue_ready_i     (issue_ready),
    .issue_rd_i        (issue_rd),
    .issue_rd_is_int_i (issue_rd_is_int),
    .issue_stall_o     (issue_stall),
    .hz_valid_i        (hz_valid),
    .hz_addr_i         (hz_addr),
    .hazard_o          (hazard),
    .c_p               (cp.slave),
    .core_wb_busy_i    (core_wb_busy),
    .wb_valid_o        (wb_valid),
    .wb_addr_o         (wb_addr),
    .wb_data_o         (wb_data),
    .error_o           (error),
    .outstanding_o     (outstanding)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid = 1'b1; issue_ready = 1'b1; issue_rd_is_int = 1'b1; issue_rd = rd;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic rsp(input logic [4:0] rd, input logic [31:0] data);
    cp.valid = 1'b1; cp.rd = rd; cp.data = data;
  endtask

  initial begin
    rst_ni = 1'b0; issue_valid = 1'b0; issue_ready = 1'b0; issue_rd_is_int = 1'b0;
    issue_rd = '0; hz_valid = '0; hz_addr = '0; core_wb_busy = 1'b0;
    cp.valid = 1'b0; cp.data = '0; cp.error = 1'b0; cp.dualwb = 1'b0; cp.rd = '0;

    repeat (2) tick();
    @(negedge clk);
    chk("rst_ready", 32'(cp.ready), 32'd0);
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    rst_ni = 1'b1;
    tick();
    @(negedge clk);
    chk("post_rst_ready", 32'(cp.ready), 32'd1);
    chk("post_rst_stall", 32'(issue_stall), 32'd0);
    chk("post_rst_wb_addr", 32'(wb_addr), 32'd0);

    // Basic issue / response / writeback to x5
    issue(5'd5);
    hz_valid = 4'b0001; hz_addr = 20'd5;
    rsp(5'd5, 32'h3F80_0000);
    @(negedge clk);
    chk("t1_hazard", 32'(hazard), 32'd1);
    chk("t1_outstanding", 32'(outstanding), 32'd1);
    tick();
    cp.valid = 1'b0;
    @(negedge clk);
    chk("t1_wb_valid", 32'(wb_valid), 32'd1);
    chk("t1_wb_addr", 32'(wb_addr), 32'd5);
    chk("t1_wb_data", wb_data, 32'h3F80_0000);
    chk("t1_hazard_drain", 32'(hazard), 32'd1);
    tick();
    @(negedge clk);
    chk("t1_wb_valid_after", 32'(wb_valid), 32'd0);
    chk("t1_hazard_after", 32'(hazard), 32'd0);
    chk("t1_outstanding_after", 32'(outstanding), 32'd0);
    chk("t1_wb_data_hold", wb_data, 32'h3F80_0000);

    // Fill to MAX_OUTSTANDING, then one retire releases the stall
    for (int i = 1; i <= 4; i++) begin
      issue(5'(i));
      @(negedge clk);
      chk("t2_stall", 32'(issue_stall), 32'(i == 4));
    end
    chk("t2_outstanding", 32'(outstanding), 32'd4);
    rsp(5'd1, 32'h11);
    tick();
    cp.valid = 1'b0;
    @(negedge clk);
    chk("t2_wb_valid", 32'(wb_valid), 32'd1);
    chk("t2_stall_drain", 32'(issue_stall), 32'd1);
    tick();
    @(negedge clk);
    chk("t2_stall_release", 32'(issue_stall), 32'd0);
    chk("t2_outstanding_3", 32'(outstanding), 32'd3);

    // Busy write port holds the buffer and back-pressures the channel
    core_wb_busy = 1'b1;
    rsp(5'd2, 32'hA);
    tick();
    rsp(5'd3, 32'hB);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_busy_wb_valid", 32'(wb_valid), 32'd0);
      chk("t3_busy_ready", 32'(cp.ready), 32'd0);
      tick();
    end
    core_wb_busy = 1'b0;
    @(negedge clk);
    chk("t3_free_wb_valid", 32'(wb_valid), 32'd1);
    chk("t3_free_wb_addr", 32'(wb_addr), 32'd2);
    chk("t3_free_wb_data", wb_data, 32'hA);
    chk("t3_free_ready", 32'(cp.ready), 32'd1);
    tick();
    rsp(5'd4, 32'hC);
    @(negedge clk);
    chk("t3_second_wb_valid", 32'(wb_valid), 32'd1);
    chk("t3_second_wb_addr", 32'(wb_addr), 32'd3);
    chk("t3_second_wb_data", wb_data, 32'hB);
    tick();
    cp.valid = 1'b0;
    @(negedge clk);
    chk("t3_third_wb_addr", 32'(wb_addr), 32'd4);
    chk("t3_third_wb_data", wb_data, 32'hC);
    tick();
    @(negedge clk);
    chk("t3_outstanding", 32'(outstanding), 32'd0);
    chk("t3_wb_valid_idle", 32'(wb_valid), 32'd0);

    // Error and dual-writeback responses drain without writeback
    for (int v = 0; v < 2; v++) begin
      issue(5'd7);
      hz_valid = 4'b0001; hz_addr = 20'd7;
      rsp(5'd7, 32'hDEAD);
      cp.error = (v == 0); cp.dualwb = (v == 1);
      @(negedge clk);
      chk("t4_hazard", 32'(hazard), 32'd1);
      tick();
      cp.valid = 1'b0; cp.error = 1'b0; cp.dualwb = 1'b0;
      @(negedge clk);
      chk("t4_wb_valid", 32'(wb_valid), 32'd0);
      chk("t4_error_pulse", 32'(error), 32'd1);
      tick();
      @(negedge clk);
      chk("t4_error_end", 32'(error), 32'd0);
      chk("t4_hazard_clear", 32'(hazard), 32'd0);
      chk("t4_outstanding", 32'(outstanding), 32'd0);
    end

    // Re-issue to x9 in the cycle the earlier x9 retires
    issue(5'd9);
    rsp(5'd9, 32'h99);
    tick();
    cp.valid = 1'b0;
    issue_valid = 1'b1; issue_ready = 1'b1; issue_rd_is_int = 1'b1; issue_rd = 5'd9;
    @(negedge clk);
    chk("t5_wb_valid", 32'(wb_valid), 32'd1);
    chk("t5_outstanding_same", 32'(outstanding), 32'd1);
    tick();
    issue_valid = 1'b0;
    hz_valid = 4'b0001; hz_addr = 20'd9;
    @(negedge clk);
    chk("t5_hazard_kept", 32'(hazard), 32'd1);
    chk("t5_outstanding_kept", 32'(outstanding), 32'd1);
    rsp(5'd9, 32'h98);
    tick();
    cp.valid = 1'b0;
    @(negedge clk);
    chk("t5_wb_data", wb_data, 32'h98);
    tick();
    @(negedge clk);
    chk("t5_hazard_clear", 32'(hazard), 32'd0);
    chk("t5_outstanding_zero", 32'(outstanding), 32'd0);

    // Unexpected response with nothing outstanding
    rsp(5'd3, 32'h33);
    @(negedge clk);
    chk("t6_drop_ready", 32'(cp.ready), 32'd1);
    tick();
    cp.valid = 1'b0;
    @(negedge clk);
    chk("t6_drop_wb_valid", 32'(wb_valid), 32'd0);
    chk("t6_drop_error", 32'(error), 32'd1);
    chk("t6_drop_outstanding", 32'(outstanding), 32'd0);
    tick();
    @(negedge clk);
    chk("t6_drop_error_end", 32'(error), 32'd0);

    // Reset with one buffered entry and two outstanding
    issue(5'd10);
    issue(5'd11);
    core_wb_busy = 1'b1;
    rsp(5'd10, 32'hAA);
    tick();
    cp.valid = 1'b0;
    @(negedge clk);
    chk("t6_pre_rst_outstanding", 32'(outstanding), 32'd2);
    rst_ni = 1'b0;
    @(negedge clk);
    chk("t6_rst_ready", 32'(cp.ready), 32'd0);
    tick();
    rst_ni = 1'b1;
    core_wb_busy = 1'b0;
    hz_valid = 4'b0011; hz_addr = {5'd0, 5'd0, 5'd11, 5'd10};
    @(negedge clk);
    chk("t6_rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("t6_rst_outstanding", 32'(outstanding), 32'd0);
    chk("t6_rst_hazard", 32'(hazard), 32'd0);
    chk("t6_rst_wb_addr", 32'(wb_addr), 32'd0);

    // Issue while stalled saturates the counter and flags an error
    for (int i = 0; i < 5; i++) issue(5'd0);
    @(negedge clk);
    chk("t7_sat_outstanding", 32'(outstanding), 32'd4);
    chk("t7_overflow_error", 32'(error), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
